// File: rtl/fp_multiplier.sv
// IEEE-754 single-precision multiplier with stb/ack handshakes on both sides.
// Multi-cycle FSM: one normalisation shift per cycle, round-to-nearest-even.
module fp_multiplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] input_a,
  input  logic [31:0] input_b,
  input  logic        input_stb,
  output logic        input_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [3:0] {
    GET_OPERANDS,
    UNPACK,
    SPECIAL_CASES,
    NORMALISE_A,
    NORMALISE_B,
    MULTIPLY_0,
    MULTIPLY_1,
    NORMALISE_1,
    NORMALISE_2,
    ROUND,
    PACK,
    PUT_Z
  } state_t;

  state_t state, state_nxt;

  logic [31:0]        a, b, z;
  logic [23:0]        a_m, b_m, z_m;
  logic signed [9:0]  a_e, b_e, z_e;
  logic               a_s, b_s, z_s;
  logic               guard, round_bit, sticky;
  logic [47:0]        product;

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic is_nan, is_inf, is_zero;
  logic norm1_shift, norm1_again, norm2_shift;
  logic [7:0]  z_exp_field;
  logic [31:0] z_packed;

  assign a_nan  = (a_e == 10'sd128) && (a_m != '0);
  assign b_nan  = (b_e == 10'sd128) && (b_m != '0);
  assign a_inf  = (a_e == 10'sd128) && (a_m == '0);
  assign b_inf  = (b_e == 10'sd128) && (b_m == '0);
  assign a_zero = (a_e == -10'sd127) && (a_m == '0);
  assign b_zero = (b_e == -10'sd127) && (b_m == '0);

  assign is_nan  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
  assign is_inf  = a_inf || b_inf;
  assign is_zero = a_zero || b_zero;

  // normalise_1 looks one shift ahead so a single-bit shift costs no extra cycle
  assign norm1_shift = !z_m[23] && (z_e > -10'sd126);
  assign norm1_again = !z_m[22] && (z_e > -10'sd125);
  assign norm2_shift = z_e < -10'sd126;

  assign z_exp_field = z_e[7:0] + 8'd127;

  always_comb begin
    z_packed = {z_s, z_exp_field, z_m[22:0]};
    if (z_e > 10'sd127)
      z_packed = {z_s, 8'hFF, 23'd0};
    else if ((z_e == -10'sd126) && !z_m[23])
      z_packed = {z_s, 8'd0, z_m[22:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= GET_OPERANDS;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      GET_OPERANDS:  if (input_ack && input_stb) state_nxt = UNPACK;
      UNPACK:        state_nxt = SPECIAL_CASES;
      SPECIAL_CASES: state_nxt = (is_nan || is_inf || is_zero) ? PUT_Z : NORMALISE_A;
      NORMALISE_A:   if (a_m[23]) state_nxt = NORMALISE_B;
      NORMALISE_B:   if (b_m[23]) state_nxt = MULTIPLY_0;
      MULTIPLY_0:    state_nxt = MULTIPLY_1;
      MULTIPLY_1:    state_nxt = NORMALISE_1;
      NORMALISE_1:   if (!norm1_shift || !norm1_again) state_nxt = NORMALISE_2;
      NORMALISE_2:   if (!norm2_shift) state_nxt = ROUND;
      ROUND:         state_nxt = PACK;
      PACK:          state_nxt = PUT_Z;
      PUT_Z:         if (output_z_stb && output_z_ack) state_nxt = GET_OPERANDS;
      default:       state_nxt = GET_OPERANDS;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      input_ack    <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= '0;
      a            <= '0;
      b            <= '0;
      z            <= '0;
      a_m          <= '0;
      b_m          <= '0;
      z_m          <= '0;
      a_e          <= '0;
      b_e          <= '0;
      z_e          <= '0;
      a_s          <= 1'b0;
      b_s          <= 1'b0;
      z_s          <= 1'b0;
      guard        <= 1'b0;
      round_bit    <= 1'b0;
      sticky       <= 1'b0;
      product      <= '0;
    end else begin
      case (state)
        GET_OPERANDS: begin
          input_ack <= 1'b1;
          if (input_ack && input_stb) begin
            a         <= input_a;
            b         <= input_b;
            input_ack <= 1'b0;
          end
        end
        UNPACK: begin
          a_m <= {1'b0, a[22:0]};
          b_m <= {1'b0, b[22:0]};
          a_e <= $signed({2'b00, a[30:23]}) - 10'sd127;
          b_e <= $signed({2'b00, b[30:23]}) - 10'sd127;
          a_s <= a[31];
          b_s <= b[31];
        end
        SPECIAL_CASES: begin
          if (is_nan) begin
            z <= 32'hFFC00000;
          end else if (is_inf) begin
            z <= {a_s ^ b_s, 8'hFF, 23'd0};
          end else if (is_zero) begin
            z <= {a_s ^ b_s, 31'd0};
          end else begin
            if (a_e == -10'sd127) a_e <= -10'sd126;
            else                  a_m[23] <= 1'b1;
            if (b_e == -10'sd127) b_e <= -10'sd126;
            else                  b_m[23] <= 1'b1;
          end
        end
        NORMALISE_A: begin
          if (!a_m[23]) begin
            a_m <= {a_m[22:0], 1'b0};
            a_e <= a_e - 10'sd1;
          end
        end
        NORMALISE_B: begin
          if (!b_m[23]) begin
            b_m <= {b_m[22:0], 1'b0};
            b_e <= b_e - 10'sd1;
          end
        end
        MULTIPLY_0: begin
          z_s     <= a_s ^ b_s;
          z_e     <= a_e + b_e + 10'sd1;
          product <= {24'd0, a_m} * {24'd0, b_m};
        end
        MULTIPLY_1: begin
          z_m       <= product[47:24];
          guard     <= product[23];
          round_bit <= product[22];
          sticky    <= |product[21:0];
        end
        NORMALISE_1: begin
          if (norm1_shift) begin
            z_m       <= {z_m[22:0], guard};
            guard     <= round_bit;
            round_bit <= 1'b0;
            z_e       <= z_e - 10'sd1;
          end
        end
        NORMALISE_2: begin
          if (norm2_shift) begin
            z_m       <= {1'b0, z_m[23:1]};
            z_e       <= z_e + 10'sd1;
            guard     <= z_m[0];
            round_bit <= guard;
            sticky    <= sticky | round_bit;
          end
        end
        ROUND: begin
          if (guard && (round_bit || sticky || z_m[0])) begin
            z_m <= z_m + 24'd1;
            if (z_m == 24'hFFFFFF) z_e <= z_e + 10'sd1;
          end
        end
        PACK: z <= z_packed;
        PUT_Z: begin
          output_z_stb <= 1'b1;
          output_z     <= z;
          if (output_z_stb && output_z_ack) output_z_stb <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fp_multiplier.md
FP_MULTIPLIER -- requirements
Module: fp_multiplier

Interface
REQ-001 SHALL have no parameters; the format is fixed to IEEE-754 single precision.
REQ-002 clk  input  1  clock, all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 input_a  input  32  multiplicand, IEEE-754 single.
REQ-005 input_b  input  32  multiplier, IEEE-754 single.
REQ-006 input_stb  input  1  upstream asserts when input_a/input_b are valid.
REQ-007 input_ack  output  1  block ready to accept operands.
REQ-008 output_z  output  32  product, IEEE-754 single.
REQ-009 output_z_stb  output  1  output_z valid.
REQ-010 output_z_ack  input  1  downstream (divider) accepts output_z.

Function
REQ-011 SHALL implement FSM states: get_operands, unpack, special_cases, normalise_a, normalise_b, multiply_0, multiply_1, normalise_1, normalise_2, round, pack, put_z.
REQ-012 get_operands: SHALL drive input_ack=1 from the cycle after entry; on an edge with input_ack&&input_stb, SHALL latch both operands, drop input_ack, go to unpack.
REQ-013 unpack: SHALL split sign, 23-bit mantissa, unbiased 10-bit signed exponent (field-127) per operand.
REQ-014 special_cases, priority order: either NaN -> 0xFFC00000; inf times zero -> 0xFFC00000; either inf -> sign a_s^b_s, exp 255, mantissa 0; either zero -> sign a_s^b_s, all else 0; each goes directly to put_z.
REQ-015 Otherwise SHALL set hidden bit for normals, set exponent -126 for denormals, go to normalise_a.
REQ-016 normalise_a/normalise_b: while mantissa[23]==0, SHALL shift mantissa left 1 and decrement exponent, one bit per cycle.
REQ-017 multiply_0: SHALL compute z_s=a_s^b_s, z_e=a_e+b_e+1, 48-bit product=a_m*b_m.
REQ-018 multiply_1: SHALL take z_m=product[47:24], guard=product[23], round_bit=product[22], sticky=|product[21:0].
REQ-019 normalise_1: while z_m[23]==0 and z_e>-126, SHALL shift z_m left, shift guard into z_m[0], round_bit into guard, clear round_bit, decrement z_e.
REQ-020 normalise_2: while z_e<-126, SHALL shift z_m right, increment z_e, z_m[0]->guard, guard->round_bit, sticky|=round_bit.
REQ-021 round: round-to-nearest-even; increment z_m when guard&&(round_bit|sticky|z_m[0]); if z_m was 0xFFFFFF, SHALL increment z_e.
REQ-022 pack: exponent field z_e+127; field 0 when z_e==-126 and z_m[23]==0; z_e>127 SHALL give signed infinity.
REQ-023 put_z: SHALL set output_z_stb=1 with output_z=z; on edge with output_z_stb&&output_z_ack, drop strobe, return to get_operands.
REQ-024 output_z SHALL stay constant while output_z_stb=1; output_z_ack while strobe low SHALL be ignored.
REQ-025 Latency, normal operands, no normalisation shifts: output_z_stb SHALL rise exactly 11 edges after the capture edge; special cases exactly 3.
REQ-026 input_stb while the block is busy SHALL be ignored; input_ack SHALL be 0 outside get_operands.

Reset
REQ-027 rst_n low SHALL force state=get_operands, input_ack=0, output_z_stb=0, output_z=0 immediately, including mid-calculation; the partial result SHALL be discarded.
REQ-028 After release, input_ack SHALL rise on the first rising edge.

Verification
REQ-029 0x40000000 x 0x40400000 (2.0x3.0) -> 0x40C00000, strobe 11 edges after capture.
REQ-030 0x3FC00000 x 0xC0000000 -> 0xC0400000; 0x7F800000 x 0x00000000 -> 0xFFC00000.
REQ-031 0x7F000000 x 0x7F000000 -> 0x7F800000 (overflow); 0x00800000 x 0x3F000000 -> 0x00400000 (denormal result).
REQ-032 Random normals vs real-valued model, RNE -> bit-exact, 10k vectors including denormal inputs.
REQ-033 output_z_ack held low 5 cycles -> output_z_stb and output_z stable; ack then -> strobe drops next edge, input_ack high one edge later.
REQ-034 rst_n pulsed low during multiply_1 -> all outputs 0 at once; next operand pair 2.0x3.0 -> 0x40C00000.
